ctrl_pipe: RTL and testbench

CTRL_PIPE -- requirements
Module: ctrl_pipe

---
 rtl/ctrl_pipe.sv | 156 +++++++++++++++
 tb/tb_ctrl_pipe.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe.sv
// Control pipeline for a 5-stage core: decodes the ID instruction, detects
// load-use hazards and carries the control bundles through EX, MEM and WB.
module ctrl_pipe #(
    parameter int ENABLE_JUMP = 1,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [4:0]       rd,
    input  logic             id_valid,
    input  logic             stall_ext,
    input  logic             flush,
    output logic             id_stall,
    output logic             id_illegal,
    output logic             ex_valid,
    output logic             ex_alu_src,
    output logic [1:0]       ex_alu_op,
    output logic             ex_branch,
    output logic             ex_jump,
    output logic [4:0]       ex_rd,
    output logic             mem_valid,
    output logic             mem_MemRead,
    output logic             mem_MemWrite,
    output logic [4:0]       mem_rd,
    output logic             wb_valid,
    output logic             wb_RegWrite,
    output logic             wb_MemtoReg,
    output logic             wb_link,
    output logic [4:0]       wb_rd,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IA   = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_ST   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    // Control word layout: {reg_write, mem_to_reg, mem_read, mem_write,
    // alu_src, branch, jump, link, alu_op[1:0]}
    localparam int C_RW  = 9;
    localparam int C_M2R = 8;
    localparam int C_MR  = 7;
    localparam int C_MW  = 6;
    localparam int C_SRC = 5;
    localparam int C_BR  = 4;
    localparam int C_JMP = 3;
    localparam int C_LNK = 2;

    logic [9:0] dec_ctrl;
    logic       dec_legal;
    logic       rs1_used;
    logic       rs2_used;
    logic       hazard;
    logic       issue;

    logic [9:0] ex_ctrl;
    logic       mem_reg_write;
    logic       mem_mem_to_reg;
    logic       mem_link;

    always_comb begin
        dec_ctrl  = '0;
        dec_legal = 1'b0;
        case (opcode)
            OP_R:    begin dec_ctrl = 10'b1000000010; dec_legal = 1'b1; end
            OP_IA:   begin dec_ctrl = 10'b1000100011; dec_legal = 1'b1; end
            OP_LD:   begin dec_ctrl = 10'b1110100000; dec_legal = 1'b1; end
            OP_ST:   begin dec_ctrl = 10'b0001100000; dec_legal = 1'b1; end
            OP_BR:   begin dec_ctrl = 10'b0000010001; dec_legal = 1'b1; end
            OP_JAL: begin
                if (ENABLE_JUMP != 0) begin
                    dec_ctrl  = 10'b1000001100;
                    dec_legal = 1'b1;
                end
            end
            OP_JALR: begin
                if (ENABLE_JUMP != 0) begin
                    dec_ctrl  = 10'b1000101100;
                    dec_legal = 1'b1;
                end
            end
            default: begin
                dec_ctrl  = '0;
                dec_legal = 1'b0;
            end
        endcase
    end

    // jal has no rs1 operand; only R, store and branch actually read rs2
    always_comb begin
        rs1_used   = (opcode != OP_JAL);
        rs2_used   = (opcode == OP_R) || (opcode == OP_ST) || (opcode == OP_BR);
        hazard     = id_valid && ex_valid && ex_ctrl[C_MR] && (ex_rd != 5'd0) &&
                     (((ex_rd == rs1) && rs1_used) || ((ex_rd == rs2) && rs2_used));
        id_stall   = hazard && !flush && !stall_ext;
        id_illegal = id_valid && !dec_legal;
        issue      = id_valid && !flush && !hazard && dec_legal;
    end

    assign ex_alu_src = ex_ctrl[C_SRC];
    assign ex_alu_op  = ex_ctrl[1:0];
    assign ex_branch  = ex_ctrl[C_BR];
    assign ex_jump    = ex_ctrl[C_JMP];

    // Bubbles carry an all-zero bundle, so nothing downstream needs a valid gate
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid       <= 1'b0;
            ex_ctrl        <= '0;
            ex_rd          <= '0;
            mem_valid      <= 1'b0;
            mem_reg_write  <= 1'b0;
            mem_mem_to_reg <= 1'b0;
            mem_link       <= 1'b0;
            mem_MemRead    <= 1'b0;
            mem_MemWrite   <= 1'b0;
            mem_rd         <= '0;
            wb_valid       <= 1'b0;
            wb_RegWrite    <= 1'b0;
            wb_MemtoReg    <= 1'b0;
            wb_link        <= 1'b0;
            wb_rd          <= '0;
        end else if (!stall_ext) begin
            ex_valid       <= issue;
            ex_ctrl        <= issue ? dec_ctrl : 10'd0;
            ex_rd          <= issue ? rd : 5'd0;
            mem_valid      <= ex_valid;
            mem_reg_write  <= ex_ctrl[C_RW];
            mem_mem_to_reg <= ex_ctrl[C_M2R];
            mem_link       <= ex_ctrl[C_LNK];
            mem_MemRead    <= ex_ctrl[C_MR];
            mem_MemWrite   <= ex_ctrl[C_MW];
            mem_rd         <= ex_rd;
            wb_valid       <= mem_valid;
            wb_RegWrite    <= mem_reg_write;
            wb_MemtoReg    <= mem_mem_to_reg;
            wb_link        <= mem_link;
            wb_rd          <= mem_rd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (id_stall && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ctrl_pipe.sv
// Scoreboard bench for ctrl_pipe: directed vectors push expected bundles into
// per-stage queues and a monitor pops them whenever a stage shows a valid entry.
module tb_ctrl_pipe;

    localparam logic [6:0] R    = 7'b0110011;
    localparam logic [6:0] IA   = 7'b0010011;
    localparam logic [6:0] LD   = 7'b0000011;
    localparam logic [6:0] ST   = 7'b0100011;
    localparam logic [6:0] BR   = 7'b1100011;
    localparam logic [6:0] JAL  = 7'b1101111;
    localparam logic [6:0] JALR = 7'b1100111;
    localparam logic [6:0] LUI  = 7'b0110111;

    typedef struct packed {
        logic       rw, m2r, mr, mw, src, br, jmp, lnk;
        logic [1:0] aop;
    } ctrl_t;

    typedef struct packed {
        logic [6:0] op;
        logic [4:0] rd;
    } entry_t;

    logic       clk, rst;
    logic [6:0] opcode;
    logic [4:0] rs1, rs2, rd;
    logic       id_valid, stall_ext, flush;
    logic       id_stall, id_illegal;
    logic       ex_valid, ex_alu_src, ex_branch, ex_jump;
    logic [1:0] ex_alu_op;
    logic [4:0] ex_rd;
    logic       mem_valid, mem_MemRead, mem_MemWrite;
    logic [4:0] mem_rd;
    logic       wb_valid, wb_RegWrite, wb_MemtoReg, wb_link;
    logic [4:0] wb_rd;
    logic [3:0] stall_cnt;

    logic       j0_id_stall, j0_id_illegal;
    logic       j0_ex_valid, j0_ex_alu_src, j0_ex_branch, j0_ex_jump;
    logic [1:0] j0_ex_alu_op;
    logic [4:0] j0_ex_rd;
    logic       j0_mem_valid, j0_mem_MemRead, j0_mem_MemWrite;
    logic [4:0] j0_mem_rd;
    logic       j0_wb_valid, j0_wb_RegWrite, j0_wb_MemtoReg, j0_wb_link;
    logic [4:0] j0_wb_rd;
    logic [3:0] j0_stall_cnt;

    int compared   = 0;
    int mismatched = 0;
    entry_t ex_q[$];
    entry_t mem_q[$];
    entry_t wb_q[$];
    logic   mon_adv;
    entry_t mon_e;
    ctrl_t  mon_c;

    ctrl_pipe #(.ENABLE_JUMP(1), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .rs1(rs1), .rs2(rs2), .rd(rd),
        .id_valid(id_valid), .stall_ext(stall_ext), .flush(flush),
        .id_stall(id_stall), .id_illegal(id_illegal),
        .ex_valid(ex_valid), .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op),
        .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_rd(ex_rd),
        .mem_valid(mem_valid), .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite),
        .mem_rd(mem_rd), .wb_valid(wb_valid), .wb_RegWrite(wb_RegWrite),
        .wb_MemtoReg(wb_MemtoReg), .wb_link(wb_link), .wb_rd(wb_rd),
        .stall_cnt(stall_cnt)
    );

    ctrl_pipe #(.ENABLE_JUMP(0), .CNT_W(4)) dut_nojump (
        .clk(clk), .rst(rst), .opcode(opcode), .rs1(rs1), .rs2(rs2), .rd(rd),
        .id_valid(id_valid), .stall_ext(stall_ext), .flush(flush),
        .id_stall(j0_id_stall), .id_illegal(j0_id_illegal),
        .ex_valid(j0_ex_valid), .ex_alu_src(j0_ex_alu_src), .ex_alu_op(j0_ex_alu_op),
        .ex_branch(j0_ex_branch), .ex_jump(j0_ex_jump), .ex_rd(j0_ex_rd),
        .mem_valid(j0_mem_valid), .mem_MemRead(j0_mem_MemRead),
        .mem_MemWrite(j0_mem_MemWrite), .mem_rd(j0_mem_rd), .wb_valid(j0_wb_valid),
        .wb_RegWrite(j0_wb_RegWrite), .wb_MemtoReg(j0_wb_MemtoReg),
        .wb_link(j0_wb_link), .wb_rd(j0_wb_rd), .stall_cnt(j0_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-written decode table: RegWrite/MemtoReg/MemRead/MemWrite/alu_src/branch/jump/link/alu_op
    function automatic ctrl_t ctrl_of(input logic [6:0] op);
        ctrl_t c;
        c = '0;
        case (op)
            R:    c = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10};
            IA:   c = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11};
            LD:   c = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00};
            ST:   c = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00};
            BR:   c = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01};
            JAL:  c = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00};
            JALR: c = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00};
            default: c = '0;
        endcase
        return c;
    endfunction

    task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic report_empty(input string name);
        compared++;
        mismatched++;
        $display("[TB] FAIL %s: actual=valid entry required=no pending instruction at %0t", name, $time);
    endtask

    task automatic apply_stimulus(input logic v, input logic [6:0] op, input logic [4:0] s1,
                                  input logic [4:0] s2, input logic [4:0] d, input logic fl,
                                  input logic se, input logic en, input logic st, input logic ill);
        @(negedge clk);
        id_valid  = v;
        opcode    = op;
        rs1       = s1;
        rs2       = s2;
        rd        = d;
        flush     = fl;
        stall_ext = se;
        #1;
        check_output("id_stall", 16'(id_stall), 16'(st));
        check_output("id_illegal", 16'(id_illegal), 16'(ill));
        if (en) begin
            ex_q.push_back('{op, d});
            mem_q.push_back('{op, d});
            wb_q.push_back('{op, d});
        end
    endtask

    task automatic next_edge;
        @(posedge clk);
        #2;
    endtask

    task automatic check_all_clear(input string tag);
        check_output({tag, "_ex"}, 16'({ex_valid, ex_alu_src, ex_alu_op, ex_branch, ex_jump, ex_rd}), 16'd0);
        check_output({tag, "_mem"}, 16'({mem_valid, mem_MemRead, mem_MemWrite, mem_rd}), 16'd0);
        check_output({tag, "_wb"}, 16'({wb_valid, wb_RegWrite, wb_MemtoReg, wb_link, wb_rd}), 16'd0);
        check_output({tag, "_stall_cnt"}, 16'(stall_cnt), 16'd0);
    endtask

    // Monitor: after every advancing edge, each valid stage consumes one expected entry
    always @(posedge clk) begin
        mon_adv = !rst && !stall_ext;
        #1;
        if (mon_adv && !rst) begin
            if (ex_valid) begin
                if (ex_q.size() == 0) report_empty("ex_unexpected");
                else begin
                    mon_e = ex_q.pop_front();
                    mon_c = ctrl_of(mon_e.op);
                    check_output("ex_bundle", 16'({ex_alu_src, ex_alu_op, ex_branch, ex_jump, ex_rd}),
                                 16'({mon_c.src, mon_c.aop, mon_c.br, mon_c.jmp, mon_e.rd}));
                end
            end else begin
                check_output("ex_bubble", 16'({ex_alu_src, ex_alu_op, ex_branch, ex_jump, ex_rd}), 16'd0);
            end
            if (mem_valid) begin
                if (mem_q.size() == 0) report_empty("mem_unexpected");
                else begin
                    mon_e = mem_q.pop_front();
                    mon_c = ctrl_of(mon_e.op);
                    check_output("mem_bundle", 16'({mem_MemRead, mem_MemWrite, mem_rd}),
                                 16'({mon_c.mr, mon_c.mw, mon_e.rd}));
                end
            end else begin
                check_output("mem_bubble", 16'({mem_MemRead, mem_MemWrite, mem_rd}), 16'd0);
            end
            if (wb_valid) begin
                if (wb_q.size() == 0) report_empty("wb_unexpected");
                else begin
                    mon_e = wb_q.pop_front();
                    mon_c = ctrl_of(mon_e.op);
                    check_output("wb_bundle", 16'({wb_RegWrite, wb_MemtoReg, wb_link, wb_rd}),
                                 16'({mon_c.rw, mon_c.m2r, mon_c.lnk, mon_e.rd}));
                end
            end else begin
                check_output("wb_bubble", 16'({wb_RegWrite, wb_MemtoReg, wb_link, wb_rd}), 16'd0);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: actual=still running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; opcode = '0; rs1 = '0; rs2 = '0; rd = '0;
        id_valid = 1'b0; stall_ext = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check_all_clear("reset");
        @(negedge clk);
        rst = 1'b0;

        // load-use: ld x5 then add rs1=x5 stalls once
        apply_stimulus(1, LD, 1, 0, 5, 0, 0, 1, 0, 0);
        check_output("nojump_ld_legal", 16'(j0_id_illegal), 16'd0);
        apply_stimulus(1, R, 5, 2, 6, 0, 0, 0, 1, 0);
        next_edge;
        check_output("ex_bubble_after_stall", 16'(ex_valid), 16'd0);
        check_output("stall_cnt_one", 16'(stall_cnt), 16'd1);
        apply_stimulus(1, R, 5, 2, 6, 0, 0, 1, 0, 0);
        next_edge;
        check_output("ex_rd_add", 16'({ex_valid, ex_rd}), 16'({1'b1, 5'd6}));
        check_output("stall_cnt_still_one", 16'(stall_cnt), 16'd1);

        // x0 destination never creates a hazard
        apply_stimulus(1, LD, 3, 0, 0, 0, 0, 1, 0, 0);
        apply_stimulus(1, R, 0, 0, 7, 0, 0, 1, 0, 0);

        // flush kills the store behind a taken branch
        apply_stimulus(1, BR, 1, 2, 0, 0, 0, 1, 0, 0);
        apply_stimulus(1, ST, 3, 4, 8, 1, 0, 0, 0, 0);
        next_edge;
        check_output("ex_flushed", 16'(ex_valid), 16'd0);
        apply_stimulus(0, 7'd0, 0, 0, 0, 0, 0, 0, 0, 0);
        next_edge;
        check_output("mem_no_write", 16'({mem_valid, mem_MemWrite}), 16'd0);

        // flush together with hazard: bubble, no stall
        apply_stimulus(1, LD, 0, 0, 9, 0, 0, 1, 0, 0);
        apply_stimulus(1, R, 9, 0, 3, 1, 0, 0, 0, 0);
        next_edge;
        check_output("stall_cnt_flush_hazard", 16'(stall_cnt), 16'd1);

        // external stall freezes the pipe for 3 cycles
        apply_stimulus(1, LD, 0, 0, 10, 0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1, R, 10, 0, 4, 0, 1, 0, 0, 0);
            next_edge;
            check_output("frozen_ex", 16'({ex_valid, ex_rd}), 16'({1'b1, 5'd10}));
            check_output("frozen_mem", 16'(mem_valid), 16'd0);
            check_output("frozen_wb", 16'({wb_valid, wb_MemtoReg, wb_rd}), 16'({1'b1, 1'b1, 5'd9}));
            check_output("frozen_stall_cnt", 16'(stall_cnt), 16'd1);
        end
        apply_stimulus(1, R, 10, 0, 4, 0, 0, 0, 1, 0);
        next_edge;
        check_output("stall_cnt_after_freeze", 16'(stall_cnt), 16'd2);
        apply_stimulus(1, R, 10, 0, 4, 0, 0, 1, 0, 0);

        // operand-usage rules for jumps, I-arith and stores
        apply_stimulus(1, IA, 1, 5, 13, 0, 0, 1, 0, 0);
        apply_stimulus(1, LD, 2, 0, 12, 0, 0, 1, 0, 0);
        apply_stimulus(1, JAL, 12, 12, 1, 0, 0, 1, 0, 0);
        check_output("nojump_jal_illegal", 16'(j0_id_illegal), 16'd1);
        apply_stimulus(1, LD, 2, 0, 12, 0, 0, 1, 0, 0);
        apply_stimulus(1, JALR, 12, 0, 1, 0, 0, 0, 1, 0);
        check_output("nojump_jalr_illegal", 16'(j0_id_illegal), 16'd1);
        apply_stimulus(1, JALR, 12, 0, 1, 0, 0, 1, 0, 0);
        apply_stimulus(1, LD, 0, 0, 14, 0, 0, 1, 0, 0);
        apply_stimulus(1, IA, 1, 14, 15, 0, 0, 1, 0, 0);
        apply_stimulus(1, LD, 0, 0, 14, 0, 0, 1, 0, 0);
        apply_stimulus(1, ST, 1, 14, 0, 0, 0, 0, 1, 0);
        apply_stimulus(1, ST, 1, 14, 0, 0, 0, 1, 0, 0);
        apply_stimulus(1, BR, 3, 4, 0, 0, 0, 1, 0, 0);

        // undecodable opcode becomes a bubble
        apply_stimulus(1, LUI, 0, 0, 11, 0, 0, 0, 0, 1);
        next_edge;
        check_output("ex_illegal_bubble", 16'(ex_valid), 16'd0);
        check_output("stall_cnt_before_sat", 16'(stall_cnt), 16'd4);
        apply_stimulus(0, LUI, 0, 0, 11, 0, 0, 0, 0, 0);

        // 21 load-use stalls saturate the 4-bit counter at 15
        for (int i = 0; i < 21; i++) begin
            if (i == 10) begin
                next_edge;
                check_output("stall_cnt_14", 16'(stall_cnt), 16'd14);
            end
            apply_stimulus(1, LD, 5, 0, 5, 0, 0, 1, 0, 0);
            apply_stimulus(1, LD, 5, 0, 5, 0, 0, 0, 1, 0);
        end
        apply_stimulus(0, 7'd0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_output("stall_cnt_saturated", 16'(stall_cnt), 16'd15);
        check_output("mem_load_inflight", 16'({mem_valid, mem_MemRead}), 16'b11);

        // asynchronous reset mid-flight
        #2;
        rst = 1'b1;
        #1;
        check_all_clear("async_reset");
        ex_q.delete();
        mem_q.delete();
        wb_q.delete();
        @(negedge clk);
        check_output("reset_held_stall_cnt", 16'(stall_cnt), 16'd0);
        rst = 1'b0;

        apply_stimulus(1, R, 1, 2, 3, 0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) apply_stimulus(0, 7'd0, 0, 0, 0, 0, 0, 0, 0, 0);
        next_edge;
        check_output("ex_q_drained", 16'(ex_q.size()), 16'd0);
        check_output("mem_q_drained", 16'(mem_q.size()), 16'd0);
        check_output("wb_q_drained", 16'(wb_q.size()), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
